decay_count_controller: RTL and testbench
=========================================

# decay_count_controller

Measurement sequencer for the random pulse generator (simulated radioactive source). It gates the generator on for a programmable counting window and detects rising edges on the generator's pulse output. A paralyzable-free (non-extending) detector dead time is applied, so each edge is either counted or recorded as lost. The saturated counts are presented to downstream logic over a valid/ready handshake, in single-shot or continuous mode.

## Interface
Parameters:
- CNT_W, 16, width of counted and lost-event counters
- WIN_W, 16, width of window length and window counter
- DEAD_W, 8, width of dead-time length and counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a measurement; honoured only in IDLE
- stop  in  1  abort; honoured in COUNT and REPORT
- continuous  in  1  sampled at start and at each REPORT handshake; 1 = auto-restart
- window_len  in  WIN_W  window length in cycles; 0 treated as 1; sampled at window start
- dead_len  in  DEAD_W  dead time in cycles after each counted edge; 0 = none; sampled at window start
- pulse_in  in  1  pulse output of the random pulse generator
- gen_en  out  1  enable to the generator; high exactly while in COUNT
- busy  out  1  high in COUNT and REPORT
- result_valid  out  1  count result available (REPORT)
- result_ready  in  1  downstream accepts result
- count_out  out  CNT_W  counted edges in last window (saturating)
- lost_out  out  CNT_W  edges dropped in dead time (saturating)
- overflow  out  1  either counter saturated during the window

## Operation
States:
- IDLE: wait for start.
- COUNT: window open, counting.
- REPORT: result held.

Transitions:
- IDLE → COUNT on start. On entry: load win_cnt with max(window_len,1) and dead_reg with dead_len, latch continuous, and clear the counters, dead_cnt and overflow.
- COUNT → REPORT when win_cnt==1 and that cycle's events have been processed.
- COUNT → IDLE on stop. Results are discarded; counters are not presented.
- REPORT → COUNT on result_valid & result_ready with latched continuous=1. Reload config as in IDLE→COUNT.
- REPORT → IDLE on result_valid & result_ready with continuous=0, or on stop.
- stop has priority over all other transitions.

Edge detection:
- pulse_q is a register of pulse_in.
- ev = pulse_in & ~pulse_q, evaluated only in COUNT.
- pulse_q keeps sampling in every state, so a high level at window start yields no event.

Dead time:
- ev with dead_cnt==0: count += 1 and dead_cnt <= dead_reg.
- ev with dead_cnt!=0: lost += 1. dead_cnt is not reloaded (non-extending).
- Otherwise dead_cnt decrements toward 0 each COUNT cycle.

Arithmetic:
- Counters saturate at 2^CNT_W-1. An increment attempted at saturation sets overflow; the counter holds.
- win_cnt decrements by 1 per COUNT cycle.

Handshake:
- result_valid, count_out, lost_out and overflow are stable in REPORT until accepted.
- result_ready is ignored outside REPORT.

## Timing
Reset values: state IDLE; gen_en, busy, result_valid and overflow = 0; count_out and lost_out = 0; pulse_q = 0.

Cycle-level behaviour:
- COUNT lasts exactly max(window_len,1) cycles.
- gen_en is registered and rises the cycle after start is sampled. The generator's first pulse therefore reaches pulse_in no earlier than one cycle after gen_en.
- result_valid rises the cycle after the last COUNT cycle.
- With continuous=1 and result_ready held high, REPORT lasts 1 cycle, so gen_en is low 1 cycle between windows.
- Edges in the final COUNT cycle are included. Edges in the REPORT and IDLE cycles are ignored.
- start and stop asserted together in IDLE: stop wins and the block stays IDLE.
- Reset asserted mid-window: immediate return to IDLE with all outputs at reset values.

## Structure
- A shared package holds the state enum (IDLE, COUNT, REPORT) and a saturating-increment function parameterised by width.
- One natural sub-module: sat_counter (clear, inc, saturate flag). It is instantiated twice, for count and lost.
- All other logic (FSM, edge detector, window and dead-time counters) stays in decay_count_controller.

## Test plan
- Single shot: window_len=10, dead_len=0, pulse_in driven with 3 one-cycle pulses inside the window → one REPORT with count_out=3, lost_out=0, gen_en high exactly 10 cycles.
- Dead time: dead_len=4, edges at window cycles 2, 4, 7 → count_out=2, lost_out=1.
- Boundary: window_len=0, edge in the only COUNT cycle → window of 1 cycle, count_out=1. Edge one cycle later is ignored.
- Saturation: CNT_W=2, 5 separated edges → count_out=3, overflow=1.
- Continuous with backpressure: continuous=1, result_ready low for 5 cycles → outputs stable for 5 cycles. After the handshake, COUNT resumes with counters at 0; a new window_len applied before the handshake takes effect.
- Abort and reset: stop mid-COUNT → IDLE, no result_valid. rst asserted mid-COUNT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/decay_count_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decay_count_controller_pkg
// Description : Shared state encoding and saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package decay_count_controller_pkg;

    localparam int c_MAX_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Widths above c_MAX_CNT_W are not supported by this helper.
    function automatic logic [c_MAX_CNT_W-1:0] sat_inc(
        input logic [c_MAX_CNT_W-1:0] value,
        input int unsigned            width
    );
        logic [c_MAX_CNT_W-1:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decay_count_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : decay_count_controller_if
// Description : Result handshake bundle (valid/ready plus counts).
// Revision    : 1.0 - initial release
// ============================================================================
interface decay_count_controller_if #(
    parameter int CNT_W = 16
) ();
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] count_out;
    logic [CNT_W-1:0] lost_out;
    logic             overflow;

    modport master (
        output result_valid, count_out, lost_out, overflow,
        input  result_ready
    );

    modport slave (
        input  result_valid, count_out, lost_out, overflow,
        output result_ready
    );
endinterface
`default_nettype wire

// File: rtl/decay_count_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Clearable saturating counter with sticky saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import decay_count_controller_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_inc,
    output logic      [WIDTH-1:0] o_value,
    output logic                  o_sat
);

    logic [WIDTH-1:0]       r_value;
    logic                   r_sat;
    logic [c_MAX_CNT_W-1:0] w_next_full;
    logic [WIDTH-1:0]       w_next;
    logic                   w_at_max;

    assign w_next_full = sat_inc(c_MAX_CNT_W'(r_value), WIDTH);
    assign w_next      = w_next_full[WIDTH-1:0];
    // The helper holds the value at the top, so "no change" means saturated.
    assign w_at_max    = (w_next == r_value);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_sat   <= 1'b0;
        end else if (i_clear) begin
            r_value <= '0;
            r_sat   <= 1'b0;
        end else if (i_inc) begin
            r_value <= w_next;
            r_sat   <= r_sat | w_at_max;
        end
    end

    assign o_value = r_value;
    assign o_sat   = r_sat;

endmodule
`default_nettype wire

// File: rtl/decay_count_controller.sv
`default_nettype none
// ============================================================================
// Module      : decay_count_controller
// Description : Gated counting window with non-extending dead time and a
//               valid/ready result port, single-shot or continuous.
// Revision    : 1.0 - initial release
// ============================================================================
module decay_count_controller
    import decay_count_controller_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int DEAD_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              stop,
    input  wire logic              continuous,
    input  wire logic [WIN_W-1:0]  window_len,
    input  wire logic [DEAD_W-1:0] dead_len,
    input  wire logic              pulse_in,
    output logic                   gen_en,
    output logic                   busy,
    decay_count_controller_if.master res
);

    state_t            r_state;
    state_t            w_next_state;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [DEAD_W-1:0] r_dead_reg;
    logic [DEAD_W-1:0] r_dead_cnt;
    logic              r_cont;
    logic              r_pulse_q;

    logic w_hs;
    logic w_load;
    logic w_ev;
    logic w_inc_count;
    logic w_inc_lost;
    logic w_sat_count;
    logic w_sat_lost;

    assign w_hs        = (r_state == ST_REPORT) && res.result_ready;
    assign w_load      = (w_next_state == ST_COUNT) && (r_state != ST_COUNT);
    assign w_ev        = (r_state == ST_COUNT) && pulse_in && !r_pulse_q;
    assign w_inc_count = w_ev && (r_dead_cnt == '0);
    assign w_inc_lost  = w_ev && (r_dead_cnt != '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) w_next_state = ST_COUNT;
            end
            ST_COUNT: begin
                if (stop)                            w_next_state = ST_IDLE;
                else if (r_win_cnt == WIN_W'(1))     w_next_state = ST_REPORT;
            end
            ST_REPORT: begin
                if (stop)      w_next_state = ST_IDLE;
                else if (w_hs) w_next_state = r_cont ? ST_COUNT : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_win_cnt  <= '0;
            r_dead_reg <= '0;
            r_dead_cnt <= '0;
            r_cont     <= 1'b0;
            r_pulse_q  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pulse_q <= pulse_in;
            if (w_load) begin
                r_win_cnt  <= (window_len == '0) ? WIN_W'(1) : window_len;
                r_dead_reg <= dead_len;
                r_cont     <= continuous;
                r_dead_cnt <= '0;
            end else if (r_state == ST_COUNT) begin
                r_win_cnt <= r_win_cnt - WIN_W'(1);
                // Lost edges do not re-arm the dead time.
                if (w_inc_count)            r_dead_cnt <= r_dead_reg;
                else if (r_dead_cnt != '0)  r_dead_cnt <= r_dead_cnt - DEAD_W'(1);
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_count (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_load),
        .i_inc   (w_inc_count),
        .o_value (res.count_out),
        .o_sat   (w_sat_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_lost (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_load),
        .i_inc   (w_inc_lost),
        .o_value (res.lost_out),
        .o_sat   (w_sat_lost)
    );

    assign gen_en           = (r_state == ST_COUNT);
    assign busy             = (r_state != ST_IDLE);
    assign res.result_valid = (r_state == ST_REPORT);
    assign res.overflow     = w_sat_count | w_sat_lost;

endmodule
`default_nettype wire

// File: tb/tb_decay_count_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_decay_count_controller
// Description : Directed self-checking bench; a second instance with a 2-bit
//               counter shares the stimulus to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decay_count_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [15:0] window_len;
    logic [7:0]  dead_len;
    logic        pulse_in;
    logic        result_ready;
    logic        gen_en;
    logic        busy;
    logic        gen_en_s;
    logic        busy_s;
    logic        gcnt_clr;
    int          gen_cycles;
    int          total;
    int          bad;

    decay_count_controller_if #(.CNT_W(16)) res_if ();
    decay_count_controller_if #(.CNT_W(2))  res_s_if ();

    assign res_if.result_ready   = result_ready;
    assign res_s_if.result_ready = result_ready;

    decay_count_controller #(.CNT_W(16), .WIN_W(16), .DEAD_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .window_len(window_len), .dead_len(dead_len), .pulse_in(pulse_in),
        .gen_en(gen_en), .busy(busy), .res(res_if)
    );

    decay_count_controller #(.CNT_W(2), .WIN_W(16), .DEAD_W(8)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .window_len(window_len), .dead_len(dead_len), .pulse_in(pulse_in),
        .gen_en(gen_en_s), .busy(busy_s), .res(res_s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gcnt_clr)    gen_cycles <= 0;
        else if (gen_en) gen_cycles <= gen_cycles + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pat bit k drives pulse_in during window cycle k+1
    task automatic run(input logic [15:0] wl, input logic [7:0] dl, input logic cont,
                       input logic [31:0] pat, input int ncyc);
        window_len = wl;
        dead_len   = dl;
        continuous = cont;
        gcnt_clr   = 1'b1;
        start      = 1'b1;
        tick();
        start    = 1'b0;
        gcnt_clr = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            pulse_in = pat[k];
            tick();
        end
        pulse_in = 1'b0;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        window_len = '0; dead_len = '0; pulse_in = 1'b0; result_ready = 1'b0;
        gcnt_clr = 1'b1;

        // Reset state
        @(negedge clk);
        check_val("rst_gen_en", gen_en, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_valid", res_if.result_valid, 0);
        check_val("rst_count", res_if.count_out, 0);
        check_val("rst_lost", res_if.lost_out, 0);
        check_val("rst_ovf", res_if.overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single shot, three one-cycle pulses at window cycles 2, 5, 8
        run(16'd10, 8'd0, 1'b0, 32'h92, 10);
        @(negedge clk);
        check_val("ss_valid", res_if.result_valid, 1);
        check_val("ss_count", res_if.count_out, 3);
        check_val("ss_lost", res_if.lost_out, 0);
        check_val("ss_gen_cycles", gen_cycles, 10);
        check_val("ss_gen_low", gen_en, 0);
        check_val("ss_sat_count", res_s_if.count_out, 3);
        check_val("ss_sat_ovf", res_s_if.overflow, 0);
        accept();
        @(negedge clk);
        check_val("ss_idle", busy, 0);

        // Dead time 4, edges at window cycles 2, 4, 7
        run(16'd10, 8'd4, 1'b0, 32'h4A, 10);
        @(negedge clk);
        check_val("dead_count", res_if.count_out, 2);
        check_val("dead_lost", res_if.lost_out, 1);
        accept();

        // Zero window length behaves as one cycle
        run(16'd0, 8'd0, 1'b0, 32'h1, 1);
        @(negedge clk);
        check_val("w0_valid", res_if.result_valid, 1);
        check_val("w0_count", res_if.count_out, 1);
        check_val("w0_gen_cycles", gen_cycles, 1);
        accept();
        run(16'd0, 8'd0, 1'b0, 32'h2, 2);
        @(negedge clk);
        check_val("w0_late_count", res_if.count_out, 0);
        check_val("w0_late_valid", res_if.result_valid, 1);
        accept();

        // Five separated edges: 2-bit instance saturates
        run(16'd10, 8'd0, 1'b0, 32'h155, 10);
        @(negedge clk);
        check_val("sat_count", res_s_if.count_out, 3);
        check_val("sat_ovf", res_s_if.overflow, 1);
        check_val("sat_wide_count", res_if.count_out, 5);
        check_val("sat_wide_ovf", res_if.overflow, 0);
        accept();

        // Continuous with backpressure; new window length before handshake
        run(16'd6, 8'd0, 1'b1, 32'h5, 6);
        window_len = 16'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_valid", res_if.result_valid, 1);
            check_val("bp_count", res_if.count_out, 2);
            tick();
        end
        accept();
        continuous = 1'b0;
        @(negedge clk);
        check_val("cont_gen_en", gen_en, 1);
        check_val("cont_cleared", res_if.count_out, 0);
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        tick();
        @(negedge clk);
        check_val("cont_still_counting", gen_en, 1);
        tick();
        @(negedge clk);
        check_val("cont_valid", res_if.result_valid, 1);
        check_val("cont_count", res_if.count_out, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        check_val("rep_stop_busy", busy, 0);
        check_val("rep_stop_valid", res_if.result_valid, 0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check_val("startstop_busy", busy, 0);

        // Abort mid-window
        run(16'd10, 8'd0, 1'b0, 32'h1, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        check_val("abort_busy", busy, 0);
        check_val("abort_gen_en", gen_en, 0);
        repeat (12) tick();
        @(negedge clk);
        check_val("abort_no_valid", res_if.result_valid, 0);

        // Asynchronous reset mid-window
        run(16'd10, 8'd0, 1'b0, 32'h1, 4);
        check_val("prerst_count", res_if.count_out, 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_gen_en", gen_en, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_count", res_if.count_out, 0);
        check_val("arst_valid", res_if.result_valid, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
